// File: rtl/des_cbc.sv
// CBC chaining controller in front of the des core; one block in flight at a time.
// Latency: upstream xfer at n -> des_valid_o at n+1; core result xfer at m -> valid_o at m+1.
// Backpressure: accept_o only in IDLE; valid_o/data_o hold in OUT until accept_i; no skid path.
//
// Ports:
//   clk_i, reset_i (sync, active-low)
//   upstream   : start_i, mode_i, key_i, iv_i, data_i, valid_i -> accept_o
//   downstream : data_o, valid_o <- accept_i
//   core side  : des_mode_o, des_key_o, des_data_o, des_valid_o <- des_accept_i
//                des_data_i, des_valid_i -> des_accept_o
module des_cbc (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        mode_i,
    input  logic [0:63] key_i,
    input  logic [0:63] iv_i,
    input  logic [0:63] data_i,
    input  logic        valid_i,
    output logic        accept_o,
    output logic [0:63] data_o,
    output logic        valid_o,
    input  logic        accept_i,
    output logic        des_mode_o,
    output logic [0:63] des_key_o,
    output logic [0:63] des_data_o,
    output logic        des_valid_o,
    input  logic        des_accept_i,
    input  logic [0:63] des_data_i,
    input  logic        des_valid_i,
    output logic        des_accept_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [0:63] chain_q, chain_d;
    logic [0:63] held_q, held_d;       // input block as received; the next chain value when decrypting
    logic        mode_q, mode_d;
    logic [0:63] key_q, key_d;
    logic [0:63] des_data_q, des_data_d;
    logic [0:63] data_out_q, data_out_d;
    logic        accept_q, accept_d;
    logic        valid_q, valid_d;
    logic        des_valid_q, des_valid_d;
    logic        des_accept_q, des_accept_d;
    logic [0:63] chain_src;

    always_comb begin
        state_d    = state_q;
        chain_d    = chain_q;
        held_d     = held_q;
        mode_d     = mode_q;
        key_d      = key_q;
        des_data_d = des_data_q;
        data_out_d = data_out_q;
        chain_src  = start_i ? iv_i : chain_q;

        case (state_q)
            ST_IDLE: begin
                // accept_q is low for the first cycle after reset, so gate on it too
                if (accept_q && valid_i) begin
                    mode_d     = mode_i;
                    key_d      = key_i;
                    held_d     = data_i;
                    des_data_d = mode_i ? data_i : (data_i ^ chain_src);
                    if (start_i) begin
                        chain_d = iv_i;
                    end
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (des_valid_q && des_accept_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (des_accept_q && des_valid_i) begin
                    if (!mode_q) begin
                        data_out_d = des_data_i;
                        chain_d    = des_data_i;
                    end else begin
                        data_out_d = des_data_i ^ chain_q;
                        chain_d    = held_q;
                    end
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (valid_q && accept_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake outputs are registered copies of the next state
        accept_d     = (state_d == ST_IDLE);
        des_valid_d  = (state_d == ST_SEND);
        des_accept_d = (state_d == ST_WAIT);
        valid_d      = (state_d == ST_OUT);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= ST_IDLE;
            chain_q      <= '0;
            held_q       <= '0;
            mode_q       <= 1'b0;
            key_q        <= '0;
            des_data_q   <= '0;
            data_out_q   <= '0;
            accept_q     <= 1'b0;
            valid_q      <= 1'b0;
            des_valid_q  <= 1'b0;
            des_accept_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            chain_q      <= chain_d;
            held_q       <= held_d;
            mode_q       <= mode_d;
            key_q        <= key_d;
            des_data_q   <= des_data_d;
            data_out_q   <= data_out_d;
            accept_q     <= accept_d;
            valid_q      <= valid_d;
            des_valid_q  <= des_valid_d;
            des_accept_q <= des_accept_d;
        end
    end

    assign accept_o     = accept_q;
    assign data_o       = data_out_q;
    assign valid_o      = valid_q;
    assign des_mode_o   = mode_q;
    assign des_key_o    = key_q;
    assign des_data_o   = des_data_q;
    assign des_valid_o  = des_valid_q;
    assign des_accept_o = des_accept_q;

endmodule

// File: tb/tb_des_cbc.sv
module tb_des_cbc;

    localparam logic [63:0] KEY = 64'h0123456789abcdef;
    localparam logic [63:0] IV  = 64'h1234567890abcdef;
    localparam logic [63:0] P0  = 64'h4e6f772069732074;
    localparam logic [63:0] P1  = 64'h68652074696d6520;
    localparam logic [63:0] P2  = 64'h666f7220616c6c20;
    localparam logic [63:0] C0  = 64'he5c7cdde872bf27c;
    localparam logic [63:0] C1  = 64'h43e934008c389c0f;
    localparam logic [63:0] C2  = 64'h683788499a7c05f6;
    localparam logic [63:0] E0  = 64'h3fa40e8a984d4815;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        start_i = 1'b0;
    logic        mode_i = 1'b0;
    logic [0:63] key_i = '0;
    logic [0:63] iv_i = '0;
    logic [0:63] data_i = '0;
    logic        valid_i = 1'b0;
    logic        accept_o;
    logic [0:63] data_o;
    logic        valid_o;
    logic        accept_i = 1'b0;
    logic        des_mode_o;
    logic [0:63] des_key_o;
    logic [0:63] des_data_o;
    logic        des_valid_o;
    logic        des_accept_i = 1'b0;
    logic [0:63] des_data_i = '0;
    logic        des_valid_i = 1'b0;
    logic        des_accept_o;

    int tests_run = 0;
    int tests_failed = 0;

    des_cbc dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .key_i        (key_i),
        .iv_i         (iv_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .accept_o     (accept_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .accept_i     (accept_i),
        .des_mode_o   (des_mode_o),
        .des_key_o    (des_key_o),
        .des_data_o   (des_data_o),
        .des_valid_o  (des_valid_o),
        .des_accept_i (des_accept_i),
        .des_data_i   (des_data_i),
        .des_valid_i  (des_valid_i),
        .des_accept_o (des_accept_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Drives one block through the DUT while acting as the des core.
    // exp_core_in is what the DUT must present to the core; core_out is the
    // core's (ECB) answer for that input; exp_out is the required CBC result.
    task automatic do_block(input string tag, input logic st, input logic md,
                            input logic [63:0] key, input logic [63:0] iv,
                            input logic [63:0] din, input logic [63:0] exp_core_in,
                            input logic [63:0] core_out, input logic [63:0] exp_out,
                            input int lat, input int hold);
        for (int i = 0; i < 50 && !accept_o; i++) @(negedge clk_i);
        chk({tag, ".accept_ready"}, accept_o, 1);
        start_i = st;
        mode_i  = md;
        key_i   = key;
        iv_i    = iv;
        data_i  = din;
        valid_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        start_i = 1'b0;
        iv_i    = 64'hdeadbeefdeadbeef;
        data_i  = 64'hdeadbeefdeadbeef;
        chk({tag, ".accept_low"}, accept_o, 0);
        chk({tag, ".des_valid"}, des_valid_o, 1);
        chk({tag, ".des_data"}, des_data_o, exp_core_in);
        chk({tag, ".des_mode"}, des_mode_o, md);
        chk({tag, ".des_key"}, des_key_o, key);
        repeat (lat) @(negedge clk_i);
        chk({tag, ".des_valid_held"}, des_valid_o, 1);
        des_accept_i = 1'b1;
        @(negedge clk_i);
        des_accept_i = 1'b0;
        chk({tag, ".des_valid_drop"}, des_valid_o, 0);
        chk({tag, ".des_accept"}, des_accept_o, 1);
        repeat (lat) @(negedge clk_i);
        des_data_i  = core_out;
        des_valid_i = 1'b1;
        @(negedge clk_i);
        des_valid_i = 1'b0;
        des_data_i  = '0;
        chk({tag, ".valid_o"}, valid_o, 1);
        chk({tag, ".data_o"}, data_o, exp_out);
        chk({tag, ".des_accept_drop"}, des_accept_o, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            chk({tag, ".bp_valid"}, valid_o, 1);
            chk({tag, ".bp_data"}, data_o, exp_out);
            chk({tag, ".bp_accept"}, accept_o, 0);
            chk({tag, ".bp_des_valid"}, des_valid_o, 0);
        end
        accept_i = 1'b1;
        @(negedge clk_i);
        accept_i = 1'b0;
        chk({tag, ".valid_drop"}, valid_o, 0);
        chk({tag, ".accept_back"}, accept_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst.accept_o", accept_o, 0);
        chk("rst.valid_o", valid_o, 0);
        chk("rst.des_valid_o", des_valid_o, 0);
        chk("rst.des_accept_o", des_accept_o, 0);
        chk("rst.data_o", data_o, 0);
        chk("rst.des_data_o", des_data_o, 0);
        chk("rst.des_key_o", des_key_o, 0);
        chk("rst.des_mode_o", des_mode_o, 0);
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("rst.accept_after", accept_o, 1);

        // FIPS 81 CBC encrypt; third block exercises 7 cycles of backpressure
        do_block("enc0", 1, 0, KEY, IV, P0, P0 ^ IV, C0, C0, 1, 0);
        do_block("enc1", 0, 0, KEY, IV, P1, P1 ^ C0, C1, C1, 3, 0);
        do_block("enc2", 0, 0, KEY, IV, P2, P2 ^ C1, C2, C2, 2, 7);

        // Decrypt: core returns D(Ci) = Pi ^ previous chain value
        do_block("dec0", 1, 1, KEY, IV, C0, C0, P0 ^ IV, P0, 1, 0);
        do_block("dec1", 0, 1, KEY, IV, C1, C1, P1 ^ C0, P1, 2, 0);
        do_block("dec2", 0, 1, KEY, IV, C2, C2, P2 ^ C1, P2, 1, 0);

        // Zero IV gives the ECB result
        do_block("ziv", 1, 0, KEY, 64'h0, P0, P0, E0, E0, 1, 0);

        // Restart on the third block
        do_block("rs0", 1, 0, KEY, IV, P0, P0 ^ IV, C0, C0, 1, 0);
        do_block("rs1", 0, 0, KEY, IV, P1, P1 ^ C0, C1, C1, 1, 0);
        do_block("rs2", 1, 0, KEY, IV, P0, P0 ^ IV, C0, C0, 1, 0);

        // Reset while waiting for the core
        for (int i = 0; i < 50 && !accept_o; i++) @(negedge clk_i);
        chk("mid.accept_ready", accept_o, 1);
        start_i = 1'b1; mode_i = 1'b0; key_i = KEY; iv_i = IV; data_i = P1; valid_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0; start_i = 1'b0;
        des_accept_i = 1'b1;
        @(negedge clk_i);
        des_accept_i = 1'b0;
        chk("mid.in_wait", des_accept_o, 1);
        reset_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b1;
        chk("mid.accept_o", accept_o, 0);
        chk("mid.valid_o", valid_o, 0);
        chk("mid.des_valid_o", des_valid_o, 0);
        chk("mid.des_accept_o", des_accept_o, 0);
        des_data_i = 64'hcafef00dcafef00d; des_valid_i = 1'b1;
        @(negedge clk_i);
        des_valid_i = 1'b0; des_data_i = '0;
        for (int i = 0; i < 3; i++) begin
            chk("mid.no_valid_o", valid_o, 0);
            @(negedge clk_i);
        end
        do_block("post0", 1, 0, KEY, IV, P0, P0 ^ IV, C0, C0, 1, 0);
        do_block("post1", 0, 0, KEY, IV, P1, P1 ^ C0, C1, C1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
